// File: rtl/key_pkg.sv
// Shared types and constants for the eight-channel key debouncer.
// Optional KEY_SYNC_EN build flag adds a 2-flop input synchronizer.
package key_pkg;

  localparam logic [7:0] KEY_RELEASED = 8'hFF;

  typedef enum logic {
    SETTLE,
    RUN
  } key_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce8_if.sv
// Key-in / encoder-out bundle between a key source and the debouncer.
// master drives the raw keys, slave is the conditioner side.
interface key_debounce8_if;

  logic [7:0] key;
  logic [7:0] data;
  logic       ei;
  logic [7:0] press;
  logic [7:0] rel;

  modport master (
    output key,
    input  data,
    input  ei,
    input  press,
    input  rel
  );

  modport slave (
    input  key,
    output data,
    output ei,
    output press,
    output rel
  );

endinterface

// File: rtl/key_debounce8_chan.sv
// One debounce channel: stable level, disagree counter and edge pulses.
// Pulses are only produced while en is high (RUN state).
module debounce_chan
  import key_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic iClk,
  input  logic iReset,
  input  logic tick,
  input  logic en,
  input  logic key,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          s_q, s_d;
  logic [CW-1:0] c_q, c_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  always_comb begin
    s_d     = s_q;
    c_d     = c_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick) begin
      if (key == s_q) begin
        c_d = '0;
      end else if (c_q == LAST) begin
        s_d     = key;
        c_d     = '0;
        press_d = en & ~key;
        rel_d   = en & key;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      s_q     <= 1'b1;
      c_q     <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_q     <= c_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = s_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/key_debounce8.sv
// Eight-key debouncer feeding an 8-to-3 priority encoder (active-low).
// Define KEY_SYNC_EN to pass iKey through a 2-flop synchronizer.
module key_debounce8
  import key_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [7:0] iKey,
  output logic [7:0] oData,
  output logic       oEI,
  output logic [7:0] oPress,
  output logic [7:0] oRelease
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam int SW = cnt_w(STABLE_TICKS);
  localparam logic [SW-1:0] SET_LAST = SW'(STABLE_TICKS - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [7:0]    key_s;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge iClk) begin
    if (iReset) div_q <= '0;
    else        div_q <= div_d;
  end

`ifdef KEY_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = iKey;
    sync2_d = sync1_q;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign key_s = sync2_q;
`else
  assign key_s = iKey;
`endif

  key_state_t    state_q;
  logic [SW-1:0] set_cnt_q;
  logic          ei_q;

  // Count STABLE_TICKS ticks after reset before enabling the encoder.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q   <= SETTLE;
      set_cnt_q <= '0;
      ei_q      <= 1'b1;
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (tick) begin
            if (set_cnt_q == SET_LAST) begin
              state_q   <= RUN;
              set_cnt_q <= '0;
              ei_q      <= 1'b0;
            end else begin
              set_cnt_q <= set_cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          ei_q <= 1'b0;
        end
        default: begin
          state_q <= SETTLE;
          ei_q    <= 1'b1;
        end
      endcase
    end
  end

  assign oEI = ei_q;

  logic run_en;
  assign run_en = (state_q == RUN);

  for (genvar i = 0; i < 8; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .iClk  (iClk),
      .iReset(iReset),
      .tick  (tick),
      .en    (run_en),
      .key   (key_s[i]),
      .level (oData[i]),
      .press (oPress[i]),
      .rel   (oRelease[i])
    );
  end

endmodule
